ultra_sonic_emulator: RTL
=========================

Name: ultra_sonic_emulator

Overview:
Behavioural-synthesizable model of an HC-SR04-style ultrasonic sensor: the responder end of the trigger/echo protocol driven by ultra_sonic. Accepts a trigger pulse and, after a fixed burst delay, returns an echo pulse whose width in clocks is programmed over a small register bus. Used on-board as a loopback target and in benches to stimulate ultra_sonic without hardware.

Parameters:
TRIG_MIN_CYCLES, 500, minimum synced trig high time for a valid trigger (10 us @ 50 MHz)
BURST_CYCLES, 22500, delay from trig fall to echo rise (450 us)
HOLDOFF_CYCLES, 3000000, dead time after echo fall before the next trigger is accepted (60 ms)
DEFAULT_ECHO_CYCLES, 29000, reset value of echo_width (approx. 10 cm)

Ports:
clk  in  1  system clock
reset_all  in  1  asynchronous active-low reset
trig  in  1  trigger from initiator (async, synchronized internally)
echo  out  1  echo pulse to initiator
addr  in  1  register select: 0 = ECHO_WIDTH, 1 = STATUS
write  in  1  write strobe, one cycle
write_data  in  32  write data (ECHO_WIDTH uses [23:0])
read_data  out  32  registered read data for addr

Behaviour:
- Reset (async, reset_all low): echo=0, read_data=0, state IDLE, echo_width=DEFAULT_ECHO_CYCLES, counters=0, sync flops=0.
- trig passes a 2-FF synchronizer; trig_s = synced value. All timing is relative to trig_s.
- FSM:
  - IDLE: on trig_s=1 -> TRIG_HIGH, hi_cnt=1.
  - TRIG_HIGH: while trig_s=1, hi_cnt increments and saturates at TRIG_MIN_CYCLES. On trig_s=0:
    - if hi_cnt>=TRIG_MIN_CYCLES -> BURST, dly_cnt=0, accepted++;
    - else -> IDLE, rejected++.
  - BURST: count BURST_CYCLES cycles. On the final cycle, latch width=echo_width, then:
    - if width=0 -> HOLDOFF (no-object case: echo never asserts);
    - else -> ECHO.
  - ECHO: echo=1 for exactly width cycles, then -> HOLDOFF.
  - HOLDOFF: count HOLDOFF_CYCLES cycles -> IDLE.
- Timing: the cycle in which trig_s is first seen low in TRIG_HIGH is cycle N. echo rises at N+BURST_CYCLES+1 and is high for exactly width clocks. echo is a registered output (glitch-free).
- trig activity during BURST, ECHO or HOLDOFF is ignored: no counts change, no state change. A trig held high when HOLDOFF expires is treated as a new rising edge in IDLE (hi_cnt starts at 1).
- ECHO_WIDTH write takes effect at the next BURST->ECHO latch. A write during ECHO does not alter the pulse in flight. Bits [31:24] are ignored; reads return them as 0.
- STATUS read layout:
  - [31] busy (state != IDLE)
  - [30:28] state encoding
  - [15:8] rejected count
  - [7:0] accepted count
  - both counts wrap modulo 256.
- read_data updates one cycle after addr changes. STATUS is read-only; writes to it are ignored.
- Simultaneous write to ECHO_WIDTH and the BURST->ECHO latch: the latch uses the pre-write value.
- Counter widths: $clog2(param+1) for each timer. The echo counter is 24 bits.

Optional Feature:
- US_EMU_JITTER_EN defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every clk. At the BURST->ECHO latch, width = echo_width + lfsr[3:0] - 8, clamped to >=1 when echo_width!=0. This models measurement noise of ±8 cycles. STATUS[27:24] reports the last applied signed offset.
- Undefined: width = echo_width exactly; STATUS[27:24]=0; no LFSR flops.

Decomposition:
- Package ultra_sonic_emu_pkg:
  - state enum (IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF, 3-bit);
  - register address constants ADDR_ECHO_WIDTH=0, ADDR_STATUS=1;
  - STATUS bit-position constants.
- Sub-module sync_2ff (1-bit, async active-low reset to 0) for trig. Everything else lives in the top module.

Test Plan (TRIG_MIN_CYCLES=10, BURST_CYCLES=20, HOLDOFF_CYCLES=50, DEFAULT_ECHO_CYCLES=100):
- Reset, 15-cycle trig pulse -> echo rises 21 cycles after synced fall, high exactly 100 cycles; STATUS[7:0]=1.
- Write ECHO_WIDTH=37, 12-cycle trig -> echo high exactly 37 cycles; 5-cycle trig -> no echo, STATUS[15:8]=1, accepted unchanged.
- Write ECHO_WIDTH=0, valid trig -> echo stays 0; busy=1 for 20+50 cycles, then STATUS[31]=0.
- Trig pulses during ECHO and HOLDOFF -> no echo change, counts unchanged. Write ECHO_WIDTH=5 mid-ECHO -> current pulse keeps 100; next pulse is 5.
- Assert reset_all mid-ECHO -> echo=0 asynchronously, STATUS=0, ECHO_WIDTH reads 100.
- 300 valid triggers -> accepted count reads 300 mod 256 = 44.

Source files
------------

// File: rtl/ultra_sonic_emu_pkg.sv
// ============================================================================
// ultra_sonic_emu_pkg : shared states, register map and STATUS layout
// Rev 1.0
// ============================================================================
`default_nettype none

package ultra_sonic_emu_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG_HIGH = 3'd1,
    BURST     = 3'd2,
    ECHO      = 3'd3,
    HOLDOFF   = 3'd4
  } state_e;

  localparam logic ADDR_ECHO_WIDTH = 1'b0;
  localparam logic ADDR_STATUS     = 1'b1;

  localparam int ECHO_W            = 24;

  localparam int STATUS_BUSY_BIT   = 31;
  localparam int STATUS_STATE_MSB  = 30;
  localparam int STATUS_STATE_LSB  = 28;
  localparam int STATUS_JIT_MSB    = 27;
  localparam int STATUS_JIT_LSB    = 24;
  localparam int STATUS_REJ_MSB    = 15;
  localparam int STATUS_REJ_LSB    = 8;
  localparam int STATUS_ACC_MSB    = 7;
  localparam int STATUS_ACC_LSB    = 0;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : single-bit two-flop synchronizer, async active-low reset to 0
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/ultra_sonic_emulator.sv
// ============================================================================
// ultra_sonic_emulator : HC-SR04-style trigger/echo responder with register bus
// Optional echo-width jitter enabled by defining US_EMU_JITTER_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module ultra_sonic_emulator
  import ultra_sonic_emu_pkg::*;
#(
  parameter int TRIG_MIN_CYCLES     = 500,
  parameter int BURST_CYCLES        = 22500,
  parameter int HOLDOFF_CYCLES      = 3000000,
  parameter int DEFAULT_ECHO_CYCLES = 29000
) (
  input  logic        clk,
  input  logic        reset_all,
  input  logic        trig,
  output logic        echo,
  input  logic        addr,
  input  logic        write,
  input  logic [31:0] write_data,
  output logic [31:0] read_data
);

  localparam int HI_W   = $clog2(TRIG_MIN_CYCLES + 1);
  localparam int DLY_W  = $clog2(BURST_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [HI_W-1:0]   HI_MAX    = HI_W'(TRIG_MIN_CYCLES);
  localparam logic [HI_W-1:0]   HI_ONE    = HI_W'(1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(BURST_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

  logic              w_trig_s;
  state_e            r_state,      w_state_nxt;
  logic [HI_W-1:0]   r_hi_cnt,     w_hi_nxt;
  logic [DLY_W-1:0]  r_dly_cnt,    w_dly_nxt;
  logic [HOLD_W-1:0] r_hold_cnt,   w_hold_nxt;
  logic [ECHO_W-1:0] r_echo_cnt,   w_echo_cnt_nxt;
  logic [7:0]        r_acc,        w_acc_nxt;
  logic [7:0]        r_rej,        w_rej_nxt;
  logic              r_echo;
  logic [ECHO_W-1:0] r_echo_width;
  logic [ECHO_W-1:0] w_width;
  logic [3:0]        w_jit;
  logic              w_latch;
  logic [31:0]       w_status;
  logic [31:0]       r_read_data;
  logic              w_unused_wdata;

  sync_2ff u_trig_sync (
    .clk   (clk),
    .rst_n (reset_all),
    .i_d   (trig),
    .o_q   (w_trig_s)
  );

  assign w_latch        = (r_state == BURST) && (r_dly_cnt == DLY_LAST);
  assign w_unused_wdata = ^write_data[31:ECHO_W];

`ifdef US_EMU_JITTER_EN
  logic [15:0]        r_lfsr;
  logic [3:0]         r_jit;
  logic [3:0]         w_offset;
  logic signed [25:0] w_width_ext;

  // lfsr[3:0] - 8 as a 4-bit two's-complement value is just an MSB flip
  assign w_offset    = r_lfsr[3:0] ^ 4'b1000;
  assign w_width_ext = $signed({2'b00, r_echo_width}) + $signed({{22{w_offset[3]}}, w_offset});

  always_comb begin
    if (r_echo_width == '0) begin
      w_width = '0;
    end else if (w_width_ext < 26'sd1) begin
      w_width = 24'd1;
    end else if (w_width_ext > 26'sd16777215) begin
      w_width = '1;
    end else begin
      w_width = w_width_ext[ECHO_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      r_lfsr <= 16'hACE1;
      r_jit  <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      if (w_latch && (r_echo_width != '0)) begin
        r_jit <= w_offset;
      end
    end
  end

  assign w_jit = r_jit;
`else
  assign w_width = r_echo_width;
  assign w_jit   = 4'd0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_hi_nxt       = r_hi_cnt;
    w_dly_nxt      = r_dly_cnt;
    w_hold_nxt     = r_hold_cnt;
    w_echo_cnt_nxt = r_echo_cnt;
    w_acc_nxt      = r_acc;
    w_rej_nxt      = r_rej;
    case (r_state)
      IDLE: begin
        if (w_trig_s) begin
          w_state_nxt = TRIG_HIGH;
          w_hi_nxt    = HI_ONE;
        end
      end
      TRIG_HIGH: begin
        if (w_trig_s) begin
          if (r_hi_cnt < HI_MAX) begin
            w_hi_nxt = r_hi_cnt + HI_ONE;
          end
        end else if (r_hi_cnt >= HI_MAX) begin
          w_state_nxt = BURST;
          w_dly_nxt   = '0;
          w_hi_nxt    = '0;
          w_acc_nxt   = r_acc + 8'd1;
        end else begin
          w_state_nxt = IDLE;
          w_hi_nxt    = '0;
          w_rej_nxt   = r_rej + 8'd1;
        end
      end
      BURST: begin
        if (w_latch) begin
          w_dly_nxt      = '0;
          w_echo_cnt_nxt = w_width;
          // zero width models "no object": skip straight to the dead time
          if (w_width == '0) begin
            w_state_nxt = HOLDOFF;
            w_hold_nxt  = '0;
          end else begin
            w_state_nxt = ECHO;
          end
        end else begin
          w_dly_nxt = r_dly_cnt + 1'b1;
        end
      end
      ECHO: begin
        if (r_echo_cnt <= 24'd1) begin
          w_state_nxt    = HOLDOFF;
          w_hold_nxt     = '0;
          w_echo_cnt_nxt = '0;
        end else begin
          w_echo_cnt_nxt = r_echo_cnt - 24'd1;
        end
      end
      HOLDOFF: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = IDLE;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      r_state    <= IDLE;
      r_hi_cnt   <= '0;
      r_dly_cnt  <= '0;
      r_hold_cnt <= '0;
      r_echo_cnt <= '0;
      r_acc      <= '0;
      r_rej      <= '0;
      r_echo     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hi_cnt   <= w_hi_nxt;
      r_dly_cnt  <= w_dly_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_echo_cnt <= w_echo_cnt_nxt;
      r_acc      <= w_acc_nxt;
      r_rej      <= w_rej_nxt;
      r_echo     <= (w_state_nxt == ECHO);
    end
  end

  always_comb begin
    w_status                                    = '0;
    w_status[STATUS_BUSY_BIT]                   = (r_state != IDLE);
    w_status[STATUS_STATE_MSB:STATUS_STATE_LSB] = r_state;
    w_status[STATUS_JIT_MSB:STATUS_JIT_LSB]     = w_jit;
    w_status[STATUS_REJ_MSB:STATUS_REJ_LSB]     = r_rej;
    w_status[STATUS_ACC_MSB:STATUS_ACC_LSB]     = r_acc;
  end

  // latch samples r_echo_width before this write lands
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      r_echo_width <= ECHO_W'(DEFAULT_ECHO_CYCLES);
      r_read_data  <= '0;
    end else begin
      if (write && (addr == ADDR_ECHO_WIDTH)) begin
        r_echo_width <= write_data[ECHO_W-1:0];
      end
      r_read_data <= (addr == ADDR_STATUS) ? w_status : {8'd0, r_echo_width};
    end
  end

  assign echo      = r_echo;
  assign read_data = r_read_data;

endmodule

`default_nettype wire
